// File: rtl/pid_loop_pkg.sv
// Shared definitions for the motor position-loop sequencer.
// Holds the FSM state encoding, the default data width and the signed
// saturation / magnitude-clip helpers used by the error and output paths.
package pid_loop_pkg;

    localparam int W_DEFAULT = 11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_STEP   = 3'd3,
        ST_APPLY  = 3'd4,
        ST_FAULT  = 3'd5
    } state_t;

    // Clamp v to the range of a (w+1)-bit two's complement value: [-2^w, 2^w-1].
    function automatic logic signed [31:0] sat_signed(input logic signed [31:0] v,
                                                      input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< w) - 32'sd1;
        lo = -(32'sd1 <<< w);
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

    // Clamp v symmetrically to [-lim, lim].
    function automatic logic signed [31:0] clip_mag(input logic signed [31:0] v,
                                                    input logic signed [31:0] lim);
        if (v > lim) begin
            return lim;
        end else if (v < -lim) begin
            return -lim;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/pid_loop_sequencer_pwm_gen.sv
// pwm_gen: free-running PWM counter 0..PWM_MAX with duty/direction
// double-buffering. New duty and direction are taken only at the counter
// wrap so a period is never cut short or stretched.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   clr_i           forces duty 0, counter 0, pwm low, dir forward
//   pend_duty_i     pending duty (cycles high per period)
//   pend_dir_i      pending direction (1 = forward)
//   load_i          pending values are valid and may be loaded at wrap
//   pwm_o, dir_o    registered motor outputs
module pwm_gen
    import pid_loop_pkg::*;
#(
    parameter int PWM_MAX = 255,
    parameter int CW      = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_i,
    input  logic [CW-1:0] pend_duty_i,
    input  logic          pend_dir_i,
    input  logic          load_i,
    output logic          pwm_o,
    output logic          dir_o
);

    localparam logic [CW-1:0] CNT_LAST = CW'(PWM_MAX);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] duty_q, duty_d;
    logic          dir_q, dir_d;
    logic          pwm_q, pwm_d;
    logic          wrap_s;

    assign wrap_s = (cnt_q == CNT_LAST);

    // Next counter, buffered duty/dir and the registered compare result.
    always_comb begin
        cnt_d  = cnt_q;
        duty_d = duty_q;
        dir_d  = dir_q;
        pwm_d  = 1'b0;
        if (clr_i) begin
            cnt_d  = {CW{1'b0}};
            duty_d = {CW{1'b0}};
            dir_d  = 1'b1;
            pwm_d  = 1'b0;
        end else begin
            cnt_d = wrap_s ? {CW{1'b0}} : (cnt_q + CW'(1));
            if (wrap_s && load_i) begin
                duty_d = pend_duty_i;
                dir_d  = pend_dir_i;
            end else begin
                duty_d = duty_q;
                dir_d  = dir_q;
            end
            // Registering the compare of the next count keeps pwm_o equal to
            // (cnt < duty) for the current cycle while coming straight from a flop.
            pwm_d = (cnt_d < duty_d);
        end
    end

    // PWM state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= {CW{1'b0}};
            duty_q <= {CW{1'b0}};
            dir_q  <= 1'b1;
            pwm_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            duty_q <= duty_d;
            dir_q  <= dir_d;
            pwm_q  <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;
    assign dir_o = dir_q;

endmodule

// File: rtl/pid_loop_sequencer.sv
// pid_loop_sequencer: sample-rate sequencer for the motor position loop.
// Once per DIV clocks it turns the latched encoder position and the setpoint
// into a saturated error for the PID datapath, strobes one PID update,
// clips the PID output and hands |u| / sign to the PWM generator.
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   enable                level run request; low returns to IDLE next cycle
//   setpoint, position    signed W+1-bit target and encoder position
//   pos_valid             one-cycle strobe qualifying position
//   pid_e                 registered saturated error to the PID
//   pid_step, pid_rst_n   PID update enable / active-low PID clear
//   pid_u                 PID output (combinational from pid_e)
//   pwm, dir              H-bridge drive, dir = 1 forward
//   busy, fault           loop active / sticky stale-encoder fault
module pid_loop_sequencer
    import pid_loop_pkg::*;
#(
    parameter int W       = W_DEFAULT,
    parameter int DIV     = 50000,
    parameter int PWM_MAX = 255,
    parameter int U_LIM   = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [W:0] setpoint,
    input  logic [W:0] position,
    input  logic       pos_valid,
    output logic [W:0] pid_e,
    output logic       pid_step,
    output logic       pid_rst_n,
    input  logic [W:0] pid_u,
    output logic       pwm,
    output logic       dir,
    output logic       busy,
    output logic       fault
);

    localparam int EW  = W + 1;
    localparam int SCW = $clog2(DIV);
    localparam int PCW = $clog2(PWM_MAX + 1);
    localparam logic [SCW-1:0] SC_LAST = SCW'(DIV - 1);

    state_t              state_q, state_d;
    logic [SCW-1:0]      sc_q, sc_d;
    logic                running_s, tick_s;
    logic [W:0]          hold_q, hold_d;
    logic                fresh_q, fresh_d;
    logic [W:0]          pid_e_q, pid_e_d;
    logic [W:0]          u_q, u_d;
    logic [PCW-1:0]      pend_duty_q, pend_duty_d;
    logic                pend_dir_q, pend_dir_d;
    logic                pend_vld_q, pend_vld_d;
    logic                pid_step_q, pid_step_d;
    logic                pid_rst_n_q, pid_rst_n_d;
    logic                busy_q, busy_d;
    logic                fault_q, fault_d;
    logic signed [W+1:0] diff_s;
    logic signed [31:0]  u_clip_s;
    logic                pwm_clr_s;

    assign running_s = (state_q != ST_IDLE) && (state_q != ST_FAULT);
    assign tick_s    = running_s && (sc_q == SC_LAST);

    // One extra bit so setpoint - position cannot wrap before saturation.
    assign diff_s   = $signed({setpoint[W], setpoint}) - $signed({hold_q[W], hold_q});
    assign u_clip_s = clip_mag(32'($signed(u_q)), 32'(U_LIM));

    // PWM is held off whenever the loop is not actively regulating.
    assign pwm_clr_s = (state_d == ST_IDLE) || (state_d == ST_FAULT);

    // FSM next-state logic; dropping enable overrides every state.
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   state_d = ST_WAIT;
                ST_WAIT: begin
                    if (tick_s) begin
                        state_d = fresh_q ? ST_SAMPLE : ST_FAULT;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                ST_SAMPLE: state_d = ST_STEP;
                ST_STEP:   state_d = ST_APPLY;
                ST_APPLY:  state_d = ST_WAIT;
                ST_FAULT:  state_d = ST_FAULT;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Sample counter, position hold, error/output capture and pending duty.
    always_comb begin
        sc_d        = sc_q;
        hold_d      = hold_q;
        fresh_d     = fresh_q;
        pid_e_d     = pid_e_q;
        u_d         = u_q;
        pend_duty_d = pend_duty_q;
        pend_dir_d  = pend_dir_q;
        pend_vld_d  = pend_vld_q;

        // The period runs off the counter alone so it stays DIV whatever the FSM does.
        if (!running_s) begin
            sc_d = {SCW{1'b0}};
        end else if (tick_s) begin
            sc_d = {SCW{1'b0}};
        end else begin
            sc_d = sc_q + SCW'(1);
        end

        // A strobe landing in SAMPLE is a new reading and must keep fresh set.
        if (pos_valid) begin
            hold_d  = position;
            fresh_d = 1'b1;
        end else if (state_q == ST_SAMPLE) begin
            fresh_d = 1'b0;
        end else begin
            fresh_d = fresh_q;
        end

        if (state_q == ST_SAMPLE) begin
            pid_e_d = EW'(sat_signed(32'(diff_s), W));
        end else begin
            pid_e_d = pid_e_q;
        end

        if (state_q == ST_STEP) begin
            u_d = pid_u;
        end else begin
            u_d = u_q;
        end

        if (state_d == ST_IDLE) begin
            pend_duty_d = {PCW{1'b0}};
            pend_dir_d  = 1'b1;
            pend_vld_d  = 1'b0;
        end else if (state_q == ST_APPLY) begin
            pend_duty_d = PCW'(u_clip_s[31] ? -u_clip_s : u_clip_s);
            pend_dir_d  = ~u_q[W];
            pend_vld_d  = 1'b1;
        end else begin
            pend_duty_d = pend_duty_q;
            pend_dir_d  = pend_dir_q;
            pend_vld_d  = pend_vld_q;
        end
    end

    // Output flags decoded from the next state so they change with the state register.
    always_comb begin
        pid_step_d  = (state_d == ST_STEP);
        pid_rst_n_d = (state_d == ST_WAIT) || (state_d == ST_SAMPLE) ||
                      (state_d == ST_STEP) || (state_d == ST_APPLY);
        busy_d      = pid_rst_n_d;
        fault_d     = (state_d == ST_FAULT);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            sc_q        <= {SCW{1'b0}};
            hold_q      <= {EW{1'b0}};
            fresh_q     <= 1'b0;
            pid_e_q     <= {EW{1'b0}};
            u_q         <= {EW{1'b0}};
            pend_duty_q <= {PCW{1'b0}};
            pend_dir_q  <= 1'b1;
            pend_vld_q  <= 1'b0;
            pid_step_q  <= 1'b0;
            pid_rst_n_q <= 1'b0;
            busy_q      <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sc_q        <= sc_d;
            hold_q      <= hold_d;
            fresh_q     <= fresh_d;
            pid_e_q     <= pid_e_d;
            u_q         <= u_d;
            pend_duty_q <= pend_duty_d;
            pend_dir_q  <= pend_dir_d;
            pend_vld_q  <= pend_vld_d;
            pid_step_q  <= pid_step_d;
            pid_rst_n_q <= pid_rst_n_d;
            busy_q      <= busy_d;
            fault_q     <= fault_d;
        end
    end

    pwm_gen #(
        .PWM_MAX (PWM_MAX),
        .CW      (PCW)
    ) u_pwm_gen (
        .clk         (clk),
        .reset       (reset),
        .clr_i       (pwm_clr_s),
        .pend_duty_i (pend_duty_q),
        .pend_dir_i  (pend_dir_q),
        .load_i      (pend_vld_q),
        .pwm_o       (pwm),
        .dir_o       (dir)
    );

    assign pid_e     = pid_e_q;
    assign pid_step  = pid_step_q;
    assign pid_rst_n = pid_rst_n_q;
    assign busy      = busy_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_pid_loop_sequencer.sv
// Directed bench for pid_loop_sequencer with a kp=11 proportional PID model.
module tb_pid_loop_sequencer;

    localparam int DIV = 100;

    logic              clk;
    logic              reset;
    logic              enable;
    logic [11:0]       setpoint;
    logic [11:0]       position;
    logic              pos_valid;
    logic signed [11:0] pid_e;
    logic              pid_step;
    logic              pid_rst_n;
    logic [11:0]       pid_u;
    logic              pwm;
    logic              dir;
    logic              busy;
    logic              fault;

    int n_chk  = 0;
    int n_pass = 0;
    int step_cnt = 0;
    bit pv_run = 1'b0;
    int pv_cnt = 0;
    int prod;

    pid_loop_sequencer #(
        .W       (11),
        .DIV     (DIV),
        .PWM_MAX (255),
        .U_LIM   (255)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .setpoint  (setpoint),
        .position  (position),
        .pos_valid (pos_valid),
        .pid_e     (pid_e),
        .pid_step  (pid_step),
        .pid_rst_n (pid_rst_n),
        .pid_u     (pid_u),
        .pwm       (pwm),
        .dir       (dir),
        .busy      (busy),
        .fault     (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PID model: u = sat12(11 * e)
    always_comb begin
        prod = 11 * int'(pid_e);
        if (prod > 2047) begin
            pid_u = 12'h7FF;
        end else if (prod < -2048) begin
            pid_u = 12'h800;
        end else begin
            pid_u = prod[11:0];
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_step(input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pid_step && n < limit);
        if (!pid_step) check("step_timeout", int'(pid_step), 1);
    endtask

    // Encoder strobe every 100 cycles, driven 2 ns after the rising edge.
    initial begin
        pos_valid = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (pv_run) begin
                pos_valid = (pv_cnt == 0);
                pv_cnt = (pv_cnt == 99) ? 0 : pv_cnt + 1;
            end else begin
                pos_valid = 1'b0;
                pv_cnt = 0;
            end
        end
    end

    // pid_step must never coincide with the PID being held in clear.
    initial begin
        forever begin
            @(negedge clk);
            if (pid_step) begin
                step_cnt++;
                check("step_while_pid_rst", int'(pid_rst_n), 1);
            end
        end
    end

    initial begin
        int n;
        int hi;
        int first;
        int s0;
        reset = 1'b1;
        enable = 1'b0;
        setpoint = 12'd0;
        position = 12'd0;
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pid_e", int'(pid_e), 0);
        check("rst_pid_step", int'(pid_step), 0);
        check("rst_pid_rst_n", int'(pid_rst_n), 0);
        check("rst_pwm", int'(pwm), 0);
        check("rst_dir", int'(dir), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_fault", int'(fault), 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Nominal forward: e = 60, u = 660 -> clipped 255
        setpoint = 12'd100;
        position = 12'd40;
        enable = 1'b1;
        @(negedge clk);
        check("busy_in_wait", int'(busy), 1);
        repeat (29) @(negedge clk);
        pv_run = 1'b1;
        // WAIT entry = cycle 0, tick at cycle 99, STEP at cycle 101
        wait_step(300, n);
        check("first_step_latency", n, DIV + 1 - 29);
        check("e_fwd", int'(pid_e), 60);
        wait_step(300, n);
        check("step_period", n, DIV);
        repeat (300) @(negedge clk);
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            hi += int'(pwm);
        end
        check("pwm_fwd_high", hi, 255);
        check("dir_fwd", int'(dir), 1);

        // Reverse: e = -10, u = -110 -> dir 0, duty 110 at next wrap
        wait_step(300, n);
        setpoint = 12'd0;
        position = 12'd10;
        wait_step(300, n);
        check("e_rev", int'(pid_e), -10);
        check("dir_held_until_wrap", int'(dir), 1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (dir && n < 300);
        check("dir_flip_window", int'(n >= 3 && n <= 258), 1);
        hi = 0;
        first = 0;
        for (int i = 0; i < 256; i++) begin
            hi += int'(pwm);
            if (i < 110) first += int'(pwm);
            @(negedge clk);
        end
        check("pwm_rev_period_start", first, 110);
        check("pwm_rev_high", hi, 110);

        // Error saturation both ways
        wait_step(300, n);
        setpoint = 12'h7FF;
        position = 12'h800;
        wait_step(300, n);
        check("e_sat_pos", int'(pid_e), 2047);
        setpoint = 12'h800;
        position = 12'h7FF;
        wait_step(300, n);
        check("e_sat_neg", int'(pid_e), -2048);

        // Stale encoder: tick at step+98, fault visible at step+99
        wait_step(300, n);
        pv_run = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fault && n < 300);
        check("fault_latency", n, DIV - 1);
        check("fault_pwm", int'(pwm), 0);
        check("fault_pid_rst_n", int'(pid_rst_n), 0);
        check("fault_busy", int'(busy), 0);
        repeat (50) @(negedge clk);
        check("fault_sticky", int'(fault), 1);
        check("fault_pwm_hold", int'(pwm), 0);
        check("fault_rst_hold", int'(pid_rst_n), 0);
        enable = 1'b0;
        @(negedge clk);
        check("fault_cleared", int'(fault), 0);
        check("idle_busy", int'(busy), 0);

        // Disable on the pid_step cycle
        setpoint = 12'd100;
        position = 12'd40;
        enable = 1'b1;
        @(negedge clk);
        repeat (29) @(negedge clk);
        pv_run = 1'b1;
        wait_step(300, n);
        check("restart_step_latency", n, DIV + 1 - 29);
        repeat (3) wait_step(300, n);
        enable = 1'b0;
        pv_run = 1'b0;
        @(negedge clk);
        check("dis_busy", int'(busy), 0);
        check("dis_pwm", int'(pwm), 0);
        check("dis_pid_rst_n", int'(pid_rst_n), 0);
        check("dis_pid_step", int'(pid_step), 0);
        s0 = step_cnt;
        hi = 0;
        for (int i = 0; i < 250; i++) begin
            @(negedge clk);
            hi += int'(pwm);
        end
        check("dis_no_step", step_cnt - s0, 0);
        check("dis_pwm_quiet", hi, 0);

        // Async reset while pwm is high
        enable = 1'b1;
        @(negedge clk);
        repeat (29) @(negedge clk);
        pv_run = 1'b1;
        repeat (4) wait_step(300, n);
        n = 0;
        while (!pwm && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("pwm_high_before_reset", int'(pwm), 1);
        #1;
        reset = 1'b0;
        pv_run = 1'b0;
        #1;
        check("arst_pwm", int'(pwm), 0);
        check("arst_pid_e", int'(pid_e), 0);
        check("arst_pid_rst_n", int'(pid_rst_n), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_dir", int'(dir), 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_reset_busy", int'(busy), 1);
        repeat (29) @(negedge clk);
        pv_run = 1'b1;
        wait_step(300, n);
        check("post_reset_step_latency", n, DIV + 1 - 29);
        check("post_reset_e", int'(pid_e), 60);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pid_loop_sequencer.md
# pid_loop_sequencer

Sample-rate sequencer for the motor position loop. It latches encoder position and setpoint once per sample period, forms the saturated error for the PID datapath, and strobes one PID update. It then saturates the PID output and converts it into a glitch-free PWM duty and a direction bit for the H-bridge. It sits between the encoder interface, the PID datapath (clock-enabled by `pid_step`, cleared by `pid_rst_n`) and the motor driver pins.

## Interface
- `W`, 11: data bit width minus 1; error and PID output are `W+1`-bit two's complement.
- `DIV`, 50000: sample period in clk cycles, ≥ 8.
- `PWM_MAX`, 255: PWM counter terminal value; the period is `PWM_MAX+1` cycles.
- `U_LIM`, 255: magnitude limit applied to PID output, ≤ `PWM_MAX`.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: reset, asynchronous, active-low.
- `enable`, in, 1: loop run request; level-sensitive.
- `setpoint`, in, W+1: target position, signed.
- `position`, in, W+1: encoder position, signed, qualified by `pos_valid`.
- `pos_valid`, in, 1: one-cycle strobe when `position` is updated.
- `pid_e`, out, W+1: registered error to PID `e_in`.
- `pid_step`, out, 1: one-cycle PID register-update enable.
- `pid_rst_n`, out, 1: PID state clear, active-low.
- `pid_u`, in, W+1: PID `u_out`, combinational from `pid_e` and PID state.
- `pwm`, out, 1: motor PWM.
- `dir`, out, 1: 1 = forward (u ≥ 0), 0 = reverse.
- `busy`, out, 1: high in all states except IDLE and FAULT.
- `fault`, out, 1: stale-encoder fault, sticky.

## Operation
- States: IDLE, WAIT, SAMPLE, STEP, APPLY, FAULT.
- IDLE:
  - `pid_rst_n`=0, duty=0, `pwm`=0, sample counter held at 0.
  - `enable`=1 → WAIT.
- Sample counter runs while not in IDLE/FAULT. `tick` is asserted when count = `DIV-1`; the counter then wraps to 0. The period is exactly `DIV` regardless of FSM state.
- Position hold register:
  - `pos_valid` loads `position` and sets `fresh`.
  - SAMPLE clears `fresh`.
  - `pos_valid` arriving in SAMPLE wins: the value is loaded and `fresh` stays set.
- WAIT:
  - On `tick` with `fresh`=1 → SAMPLE.
  - On `tick` with `fresh`=0 → FAULT.
- SAMPLE: e = `setpoint` − hold, computed at W+2 bits, saturated to [−2^W, 2^W−1] and registered into `pid_e` → STEP.
- STEP: `pid_step`=1 for exactly this cycle; `pid_u` is captured at the end of the cycle → APPLY.
- APPLY:
  - Clip u to [−`U_LIM`, `U_LIM`].
  - Pending duty = |u|, pending dir = (u ≥ 0).
  - → WAIT.
- PWM (sub-module):
  - Counter runs 0..`PWM_MAX` and wraps.
  - `pwm` = (cnt < duty).
  - Duty and `dir` load from pending only at wrap, so there is no mid-period change.
- `enable`=0 in any state → IDLE next cycle. On that same next cycle `pwm`=0, duty=0, pending cleared and `pid_rst_n`=0.
- FAULT:
  - `fault`=1, `pwm`=0, `pid_rst_n`=0.
  - Exit only via `enable`=0 → IDLE, which clears `fault`.
- `pid_rst_n`=1 in WAIT/SAMPLE/STEP/APPLY.

## Timing
- Reset values:
  - State = IDLE.
  - `pid_e`=0, `pid_step`=0, `pid_rst_n`=0, `pwm`=0, `dir`=1.
  - `busy`=0, `fault`=0, `fresh`=0, all counters 0.
- `tick` → SAMPLE on +1 cycle, STEP on +2, APPLY on +3, pending valid on +4. Duty is applied at the next PWM wrap, at most `PWM_MAX+1` cycles later.
- First `tick` occurs `DIV` cycles after entering WAIT. A `pos_valid` is therefore required within the first `DIV` cycles of enable.
- Asynchronous reset mid-operation forces all reset values immediately; no pending duty survives.
- `pid_step` never asserts while `pid_rst_n`=0.

## Structure
- Shared package/include `pid_loop_pkg`: state encodings, `sat_signed` width rule, `W` default.
- One sub-module `pwm_gen`:
  - Ports: clk, reset, clr, pending duty/dir, load-at-wrap.
  - Outputs: `pwm`, `dir`.
- FSM, sample counter, error and clip logic stay in the top level.

## Test plan
Bench settings: `W`=11, `DIV`=100, `PWM_MAX`=255, `U_LIM`=255. PID is modelled as kp=11, ki=kd=0.

- Nominal forward: setpoint=100, position=40, `pos_valid` every 100 cycles → `pid_e`=60, one `pid_step` per 100 cycles, u=660 clipped to 255, `dir`=1, `pwm` high 255 of 256 cycles.
- Error saturation: setpoint=2047, position=−2048 → `pid_e`=2047. Then setpoint=−2048, position=2047 → `pid_e`=−2048.
- Reverse: setpoint=0, position=10 → `pid_e`=−10, u=−110, `dir`=0 and duty=110, both taking effect only at the next PWM wrap.
- Stale encoder: stop `pos_valid` → `fault`=1 on the cycle after the next `tick`, with `pwm`=0 and `pid_rst_n`=0. Both stay so until `enable`=0, which returns to IDLE with `fault`=0.
- Disable during STEP: drop `enable` on the `pid_step` cycle → IDLE next cycle, `pwm`=0, `pid_rst_n`=0, no further `pid_step`.
- Async reset mid-PWM-high: assert `reset`=0 → `pwm`=0, `pid_e`=0 immediately. After release with `enable`=1, the first `tick` occurs exactly 100 cycles after WAIT entry.
